sd_dac2_stereo: RTL



---
 rtl/sd_dac2_stereo_pkg.sv | 37 +++
 rtl/sd_mod2_ch.sv | 39 +++
 rtl/sd_dac2_stereo.sv | 91 +++++++++
 3 files changed

// File: rtl/sd_dac2_stereo_pkg.sv
// rtl/sd_dac2_stereo_pkg.sv - shared widths, full-scale constant and saturating add for the stereo sigma-delta DAC
package sd_dac2_stereo_pkg;

    localparam int DATA_W = 18;
    localparam int ACC_W  = 24;
    localparam int SUM_W  = ACC_W + 2;

    // Full scale of a Q1.17 sample expressed in integrator units
    localparam logic signed [ACC_W-1:0] FS      = ACC_W'(1 << (DATA_W - 1));
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(1 << (ACC_W - 1)));

    typedef struct packed {
        logic                    clamp;
        logic signed [ACC_W-1:0] value;
    } sat_t;

    function automatic sat_t sat_add3(input logic signed [ACC_W-1:0] a,
                                      input logic signed [ACC_W-1:0] b,
                                      input logic signed [ACC_W-1:0] c);
        logic signed [SUM_W-1:0] sum;
        sat_t                    r;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
        if (sum > ACC_MAX) begin
            r.clamp = 1'b1;
            r.value = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            r.clamp = 1'b1;
            r.value = ACC_MIN[ACC_W-1:0];
        end else begin
            r.clamp = 1'b0;
            r.value = sum[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_mod2_ch.sv
// rtl/sd_mod2_ch.sv - single-channel second-order CIFB sigma-delta modulator, advanced on tick
module sd_mod2_ch
    import sd_dac2_stereo_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic signed [ACC_W-1:0] x,
    output logic                    bit_out,
    output logic                    sat_evt
);

    logic signed [ACC_W-1:0] a1;
    logic signed [ACC_W-1:0] a2;
    logic signed [ACC_W-1:0] neg_fb;
    sat_t                    s1;
    sat_t                    s2;

    // Second integrator sums the old a1, so both sums are formed from current state
    always_comb begin
        neg_fb  = bit_out ? -FS : FS;
        s1      = sat_add3(a1, x, neg_fb);
        s2      = sat_add3(a2, a1, neg_fb);
        sat_evt = tick & (s1.clamp | s2.clamp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1      <= '0;
            a2      <= '0;
            bit_out <= 1'b0;
        end else if (tick) begin
            a1      <= s1.value;
            a2      <= s2.value;
            bit_out <= ~s2.value[ACC_W-1];
        end
    end

endmodule

// File: rtl/sd_dac2_stereo.sv
// rtl/sd_dac2_stereo.sv - stereo sigma-delta DAC: tick divider, sample hold, underrun timeout, clip flag
module sd_dac2_stereo
    import sd_dac2_stereo_pkg::*;
#(
    parameter int MOD_DIV = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_in_rdy,
    input  logic signed [DATA_W-1:0] sample_in_l,
    input  logic signed [DATA_W-1:0] sample_in_r,
    output logic                     dac_out_l,
    output logic                     dac_out_r,
    output logic                     underrun,
    output logic                     clip
);

    localparam int DIV_W = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [DIV_W-1:0]         div_cnt;
    logic                     tick;
    logic [TO_W-1:0]          to_cnt;
    logic signed [DATA_W-1:0] hold_l;
    logic signed [DATA_W-1:0] hold_r;
    logic signed [ACC_W-1:0]  x_l;
    logic signed [ACC_W-1:0]  x_r;
    logic                     sat_l;
    logic                     sat_r;

    assign tick = (div_cnt == DIV_W'(MOD_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // A strobe always beats a timeout-reaching tick in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_l   <= '0;
            hold_r   <= '0;
            to_cnt   <= '0;
            underrun <= 1'b1;
        end else if (sample_in_rdy) begin
            hold_l   <= sample_in_l;
            hold_r   <= sample_in_r;
            to_cnt   <= '0;
            underrun <= 1'b0;
        end else if (tick && (to_cnt != TO_W'(TIMEOUT))) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                underrun <= 1'b1;
            end
        end
    end

    assign x_l = underrun ? '0 : {{(ACC_W - DATA_W){hold_l[DATA_W-1]}}, hold_l};
    assign x_r = underrun ? '0 : {{(ACC_W - DATA_W){hold_r[DATA_W-1]}}, hold_r};

    sd_mod2_ch u_mod_l (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .x       (x_l),
        .bit_out (dac_out_l),
        .sat_evt (sat_l)
    );

    sd_mod2_ch u_mod_r (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .x       (x_r),
        .bit_out (dac_out_r),
        .sat_evt (sat_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip <= 1'b0;
        end else if (sat_l || sat_r) begin
            clip <= 1'b1;
        end
    end

endmodule
